// File: rtl/apuf_multi_ctrl_if.sv
// Host-side request/result bundle for apuf_multi_ctrl.
// The host drives the request and the controller returns the voted result.
interface apuf_multi_ctrl_if #(
  parameter int unsigned N    = 64,
  parameter int unsigned REPS = 5
);
  localparam int unsigned OnesW = $clog2(REPS + 1);

  logic             start;
  logic [N-1:0]     challenge;
  logic [1:0]       mode;
  logic             busy;
  logic             resp_valid;
  logic             resp_bit;
  logic             timeout;
  logic [OnesW-1:0] ones_count;

  modport master (
    output start, challenge, mode,
    input  busy, resp_valid, resp_bit, timeout, ones_count
  );

  modport slave (
    input  start, challenge, mode,
    output busy, resp_valid, resp_bit, timeout, ones_count
  );
endinterface

// File: rtl/apuf_multi_ctrl.sv
// Challenge/response sequencer for K arbiter-PUF chains: single, K-XOR and interpose modes,
// with a majority vote over REPS evaluations and a per-evaluation ready timeout.
module apuf_multi_ctrl #(
  parameter int unsigned N      = 64,
  parameter int unsigned K      = 4,
  parameter int unsigned IPOS   = 32,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned TMO    = 255,
  parameter int unsigned REPS   = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  apuf_multi_ctrl_if.slave host_io,
  output logic [N-1:0]   puf_chal_low_o,
  output logic [N-1:0]   puf_chal_up_o,
  output logic [K-1:0]   puf_tig_o,
  input  logic [K-1:0]   puf_ready_i,
  input  logic [K-1:0]   puf_resp_i
);

  localparam int unsigned OnesW  = $clog2(REPS + 1);
  localparam int unsigned CntMax = (TMO > SETTLE) ? TMO : SETTLE;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE - 1);
  localparam logic [CntW-1:0]  TmoLast    = CntW'(TMO - 1);
  localparam logic [OnesW-1:0] RepsVal    = OnesW'(REPS);
  localparam logic [OnesW-1:0] HalfReps   = OnesW'(REPS / 2);
  localparam logic [K-1:0]     Chain0     = K'(1);

  typedef enum logic [2:0] {StIdle, StSetup, StFire, StWait, StNext, StDone} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     chal_q, chal_d;
  logic [N-1:0]     chal_up_q, chal_up_d;
  logic [1:0]       mode_q, mode_d;
  logic             stage_q, stage_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OnesW-1:0] rep_q, rep_d;
  logic [OnesW-1:0] ones_q, ones_d;
  logic             eval_q, eval_d;
  logic             resp_bit_q, resp_bit_d;
  logic             timeout_q, timeout_d;

  logic             is_xor, is_ipuf;
  logic [K-1:0]     sel_mask;
  logic             all_ready;
  logic             eval_now;

  // Mode 11 falls through to single-chain behaviour.
  assign is_xor  = (mode_q == 2'b01);
  assign is_ipuf = (mode_q == 2'b10);

  always_comb begin
    sel_mask = Chain0;
    if (is_xor) begin
      sel_mask = '1;
    end else if (is_ipuf && stage_q) begin
      sel_mask = ~Chain0;
    end
  end

  assign all_ready = &(puf_ready_i | ~sel_mask);

  always_comb begin
    eval_now = puf_resp_i[0];
    if (is_xor) begin
      eval_now = ^puf_resp_i;
    end else if (is_ipuf) begin
      eval_now = ^(puf_resp_i & ~Chain0);
    end
  end

  always_comb begin
    state_d    = state_q;
    chal_d     = chal_q;
    chal_up_d  = chal_up_q;
    mode_d     = mode_q;
    stage_d    = stage_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    ones_d     = ones_q;
    eval_d     = eval_q;
    resp_bit_d = resp_bit_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (host_io.start) begin
          state_d    = StSetup;
          chal_d     = host_io.challenge;
          chal_up_d  = host_io.challenge;
          mode_d     = host_io.mode;
          stage_d    = 1'b0;
          cnt_d      = '0;
          rep_d      = '0;
          ones_d     = '0;
          resp_bit_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      StSetup: begin
        if (cnt_q == SettleLast) begin
          state_d = StFire;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFire: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (all_ready) begin
          cnt_d = '0;
          if (is_ipuf && !stage_q) begin
            // Stage-1 result from the lower chain is interposed into the upper challenge.
            chal_up_d       = chal_q;
            chal_up_d[IPOS] = puf_resp_i[0];
            stage_d         = 1'b1;
            state_d         = StSetup;
          end else begin
            eval_d  = eval_now;
            state_d = StNext;
          end
        end else if (cnt_q == TmoLast) begin
          state_d    = StDone;
          timeout_d  = 1'b1;
          resp_bit_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNext: begin
        ones_d    = ones_q + OnesW'(eval_q);
        rep_d     = rep_q + 1'b1;
        stage_d   = 1'b0;
        chal_up_d = chal_q;
        cnt_d     = '0;
        if (rep_d == RepsVal) begin
          state_d    = StDone;
          resp_bit_d = (ones_d > HalfReps);
        end else begin
          state_d = StSetup;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      chal_q     <= '0;
      chal_up_q  <= '0;
      mode_q     <= 2'b00;
      stage_q    <= 1'b0;
      cnt_q      <= '0;
      rep_q      <= '0;
      ones_q     <= '0;
      eval_q     <= 1'b0;
      resp_bit_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      chal_q     <= chal_d;
      chal_up_q  <= chal_up_d;
      mode_q     <= mode_d;
      stage_q    <= stage_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      ones_q     <= ones_d;
      eval_q     <= eval_d;
      resp_bit_q <= resp_bit_d;
      timeout_q  <= timeout_d;
    end
  end

  assign puf_tig_o      = (state_q == StFire || state_q == StWait) ? sel_mask : '0;
  assign puf_chal_low_o = chal_q;
  assign puf_chal_up_o  = chal_up_q;

  assign host_io.busy       = (state_q != StIdle);
  assign host_io.resp_valid = (state_q == StDone);
  assign host_io.resp_bit   = resp_bit_q;
  assign host_io.timeout    = timeout_q;
  assign host_io.ones_count = ones_q;

endmodule
